// File: rtl/seg7_bcd_display.sv
// ============================================================================
// Module   : seg7_bcd_display
// Brief    : N-digit binary-to-BCD 7-segment display controller using a
//            sequential double-dabble engine, with overflow dashes and a
//            time-multiplexed scan output.
// Options  : SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_bcd_display #(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    output logic                  busy,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg_all,
    output logic [6:0]            seg_scan,
    output logic [DIGITS-1:0]     an
);

    localparam int c_BCD_RAW = DATA_W * 3 / 10 + 1;
    localparam int c_BCD_D   = (c_BCD_RAW > DIGITS) ? c_BCD_RAW : DIGITS;
    localparam int c_CNT_W   = $clog2(DATA_W);
    localparam int c_DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]         c_DASH     = 7'h40;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_CONV   = 2'd1;
    localparam logic [1:0] c_S_COMMIT = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_W-1:0]     r_shift;
    logic [4*c_BCD_D-1:0]  r_bcd;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [4*DIGITS-1:0]   r_disp;
    logic                  r_ovf;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_IDX_W-1:0]    r_idx;

    logic [4*c_BCD_D-1:0]  w_bcd_adj;
    logic                  w_ovf;
    logic [DIGITS-1:0]     w_blank;
    logic [6:0]            w_seg [DIGITS];

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    // Double-dabble correction: nibbles >= 5 get +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < c_BCD_D; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5) begin
                w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
            end
        end
    end

    generate
        if (c_BCD_D > DIGITS) begin : g_ovf
            assign w_ovf = |r_bcd[4*c_BCD_D-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (load) begin
                        r_shift <= value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_S_CONV;
                    end
                end
                c_S_CONV: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_S_COMMIT;
                    end
                end
                c_S_COMMIT: begin
                    r_disp  <= r_bcd[4*DIGITS-1:0];
                    r_ovf   <= w_ovf;
                    r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != c_S_IDLE);
    assign ovf  = r_ovf;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        logic v_seen;
        v_seen  = 1'b0;
        w_blank = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (r_disp[4*d +: 4] != 4'd0) begin
                v_seen = 1'b1;
            end
            w_blank[d] = ~v_seen;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            if (r_ovf) begin
                w_seg[d] = c_DASH;
            end else if (w_blank[d]) begin
                w_seg[d] = 7'h00;
            end else begin
                w_seg[d] = f_seg(r_disp[4*d +: 4]);
            end
        end
    end

    generate
        for (genvar gd = 0; gd < DIGITS; gd++) begin : g_pack
            assign seg_all[7*gd +: 7] = w_seg[gd];
        end
    endgenerate

    // Free-running scan, independent of the conversion FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == c_DIV_MAX) begin
            r_div <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign an       = DIGITS'(1) << r_idx;
    assign seg_scan = w_seg[r_idx];

endmodule

`default_nettype wire
